// File: rtl/branch_predict_resolve_pkg.sv
// Branch operation encodings and BTB counter constants shared by the
// prediction/resolution unit and its target calculator.
package BranchModesPackage;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        BEQ  = 4'd1,
        BNE  = 4'd2,
        BLTZ = 4'd3,
        BGEZ = 4'd4,
        BLEZ = 4'd5,
        BGTZ = 4'd6,
        J    = 4'd7,
        JAL  = 4'd8,
        JR   = 4'd9,
        JALR = 4'd10
    } branch_mode_t;

    localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;
    localparam logic [1:0] CTR_MAX        = 2'b11;

endpackage

// File: rtl/branch_predict_resolve_target_calc.sv
// Combinational branch decision: evaluates the taken condition from ALU flags
// and forms the resolved target address for every branch/jump mode.
module branch_target_calc
    import BranchModesPackage::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = 16,
    parameter int unsigned JUMP_W   = 26
) (
    input  logic [3:0]          mode,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [JUMP_W-1:0]   jump_addr,
    input  logic [ADDR_W-1:0]   jr_addr,
    input  logic                zero,
    input  logic                negative,
    input  logic                positive,
    output logic                valid_op,
    output logic                taken,
    output logic [ADDR_W-1:0]   target,
    output logic [ADDR_W-1:0]   pc4
);

    // Mask form keeps the jump splice legal even when ADDR_W == JUMP_W+2.
    localparam logic [ADDR_W-1:0] JMASK = ADDR_W'((64'd1 << (JUMP_W + 2)) - 64'd1);

    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] jmp_target;

    always_comb begin
        pc4        = pc + ADDR_W'(4);
        off_ext    = ADDR_W'($signed(offset));
        br_target  = pc4 + (off_ext << 2);
        jmp_target = (pc4 & ~JMASK) | (ADDR_W'(jump_addr) << 2);

        valid_op = 1'b1;
        taken    = 1'b0;
        target   = br_target;
        case (branch_mode_t'(mode))
            BEQ:  taken = zero;
            BNE:  taken = ~zero;
            BLTZ: taken = negative;
            BGEZ: taken = zero | positive;
            BLEZ: taken = negative | zero;
            BGTZ: taken = positive;
            J, JAL: begin
                taken  = 1'b1;
                target = jmp_target;
            end
            JR, JALR: begin
                taken  = 1'b1;
                target = jr_addr;
            end
            default: valid_op = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch resolution with a direct-mapped BTB (2-bit counters) for fetch-time
// next-PC prediction, a registered mispredict redirect, and saturating stats.
module branch_predict_resolve
    import BranchModesPackage::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned OFFSET_W = 16,
    parameter int unsigned JUMP_W   = 26,
    parameter int unsigned STAT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   fetch_pc,
    output logic                pred_taken,
    output logic [ADDR_W-1:0]   pred_target,
    input  logic                res_valid,
    input  logic [3:0]          res_mode,
    input  logic [ADDR_W-1:0]   res_pc,
    input  logic [OFFSET_W-1:0] res_offset,
    input  logic [JUMP_W-1:0]   res_jump_addr,
    input  logic [ADDR_W-1:0]   res_jr_addr,
    input  logic                res_zero,
    input  logic                res_negative,
    input  logic                res_positive,
    input  logic                res_pred_taken,
    input  logic [ADDR_W-1:0]   res_pred_target,
    output logic                redirect_valid,
    output logic [ADDR_W-1:0]   redirect_pc,
    output logic [STAT_W-1:0]   branch_count,
    output logic [STAT_W-1:0]   mispredict_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    logic              btb_valid  [ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [ENTRIES];
    logic [ADDR_W-1:0] btb_target [ENTRIES];
    logic [1:0]        btb_ctr    [ENTRIES];

    logic [IDX_W-1:0]  f_idx;
    logic              f_hit;
    logic [IDX_W-1:0]  r_idx;
    logic [TAG_W-1:0]  r_tag;
    logic              r_hit;

    logic              valid_op;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc4;
    logic              act;
    logic              mispredict;
    logic              unused_pc_bits;

    branch_target_calc #(
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W),
        .JUMP_W   (JUMP_W)
    ) u_calc (
        .mode      (res_mode),
        .pc        (res_pc),
        .offset    (res_offset),
        .jump_addr (res_jump_addr),
        .jr_addr   (res_jr_addr),
        .zero      (res_zero),
        .negative  (res_negative),
        .positive  (res_positive),
        .valid_op  (valid_op),
        .taken     (taken),
        .target    (target),
        .pc4       (pc4)
    );

    always_comb begin
        f_idx       = fetch_pc[IDX_W+1:2];
        f_hit       = btb_valid[f_idx] &&
                      (btb_tag[f_idx] == fetch_pc[ADDR_W-1:IDX_W+2]);
        pred_taken  = f_hit & btb_ctr[f_idx][1];
        pred_target = pred_taken ? btb_target[f_idx] : fetch_pc + ADDR_W'(4);

        r_idx      = res_pc[IDX_W+1:2];
        r_tag      = res_pc[ADDR_W-1:IDX_W+2];
        r_hit      = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);
        act        = res_valid & valid_op;
        mispredict = (taken != res_pred_taken) ||
                     (taken && (target != res_pred_target));

        unused_pc_bits = ^{fetch_pc[1:0], res_pc[1:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= '0;
            end
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            redirect_valid <= act & mispredict;
            redirect_pc    <= (act & mispredict) ? (taken ? target : pc4) : '0;

            if (act) begin
                if (r_hit) begin
                    if (taken) begin
                        btb_target[r_idx] <= target;
                        if (btb_ctr[r_idx] != CTR_MAX)
                            btb_ctr[r_idx] <= btb_ctr[r_idx] + 2'd1;
                    end else if (btb_ctr[r_idx] != 2'b00) begin
                        btb_ctr[r_idx] <= btb_ctr[r_idx] - 2'd1;
                    end
                end else if (taken) begin
                    btb_valid[r_idx]  <= 1'b1;
                    btb_tag[r_idx]    <= r_tag;
                    btb_target[r_idx] <= target;
                    btb_ctr[r_idx]    <= CTR_WEAK_TAKEN;
                end

                if (branch_count != '1)
                    branch_count <= branch_count + STAT_W'(1);
                if (mispredict && (mispredict_count != '1))
                    mispredict_count <= mispredict_count + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed-vector bench for branch_predict_resolve (ENTRIES=16, ADDR_W=32).
module tb_branch_predict_resolve;
    import BranchModesPackage::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [3:0]  res_mode;
    logic [31:0] res_pc;
    logic [15:0] res_offset;
    logic [25:0] res_jump_addr;
    logic [31:0] res_jr_addr;
    logic        res_zero, res_negative, res_positive;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    branch_predict_resolve #(
        .ADDR_W   (32),
        .ENTRIES  (16),
        .OFFSET_W (16),
        .JUMP_W   (26),
        .STAT_W   (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .res_valid        (res_valid),
        .res_mode         (res_mode),
        .res_pc           (res_pc),
        .res_offset       (res_offset),
        .res_jump_addr    (res_jump_addr),
        .res_jr_addr      (res_jr_addr),
        .res_zero         (res_zero),
        .res_negative     (res_negative),
        .res_positive     (res_positive),
        .res_pred_taken   (res_pred_taken),
        .res_pred_target  (res_pred_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic set_res(input logic [3:0] mode, input logic [31:0] pc, input logic [15:0] off,
                           input logic [25:0] jmp, input logic [31:0] jr, input logic [2:0] znp,
                           input logic pt, input logic [31:0] ptgt);
        res_valid       = 1'b1;
        res_mode        = mode;
        res_pc          = pc;
        res_offset      = off;
        res_jump_addr   = jmp;
        res_jr_addr     = jr;
        {res_zero, res_negative, res_positive} = znp;
        res_pred_taken  = pt;
        res_pred_target = ptgt;
    endtask

    // One resolution: inputs driven at negedge, sampled at posedge, outputs read #1 later.
    task automatic resolve(input logic [3:0] mode, input logic [31:0] pc, input logic [15:0] off,
                           input logic [25:0] jmp, input logic [31:0] jr, input logic [2:0] znp,
                           input logic pt, input logic [31:0] ptgt);
        @(negedge clk);
        set_res(mode, pc, off, jmp, jr, znp, pt, ptgt);
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        res_mode  = 4'(NONE);
    endtask

    task automatic probe(input string tag, input logic [31:0] pc, input logic exp_t,
                         input logic [31:0] exp_tgt);
        fetch_pc = pc;
        #1;
        check({tag, "_pred_taken"}, 32'(pred_taken), 32'(exp_t));
        check({tag, "_pred_target"}, pred_target, exp_tgt);
    endtask

    initial begin
        rst       = 1'b0;
        fetch_pc  = '0;
        res_valid = 1'b0;
        set_res(4'(NONE), '0, '0, '0, '0, 3'b000, 1'b0, '0);
        res_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Reset mid-stream: allocate an entry, then reset while a resolution is pending
        resolve(4'(BEQ), 32'h100, 16'hFFFF, '0, '0, 3'b100, 1'b0, '0);
        @(negedge clk);
        set_res(4'(JR), 32'h200, '0, '0, 32'h1234_5678, 3'b000, 1'b0, '0);
        #2 rst = 1'b0;
        #1;
        check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_branch_count", 32'(branch_count), 32'h0);
        @(posedge clk);
        #1;
        check("rst_dropped_redirect", 32'(redirect_valid), 32'h0);
        check("rst_mispredict_count", 32'(mispredict_count), 32'h0);
        probe("rst_fetch100", 32'h100, 1'b0, 32'h104);
        probe("rst_fetch200", 32'h200, 1'b0, 32'h204);
        @(negedge clk);
        res_valid = 1'b0;
        res_mode  = 4'(NONE);
        rst       = 1'b1;

        // BEQ back to itself, mispredicted not-taken
        resolve(4'(BEQ), 32'h100, 16'hFFFF, '0, '0, 3'b100, 1'b0, '0);
        check("beq_redirect_valid", 32'(redirect_valid), 32'h1);
        check("beq_redirect_pc", redirect_pc, 32'h100);
        check("beq_branch_count", 32'(branch_count), 32'd1);
        check("beq_mispredict_count", 32'(mispredict_count), 32'd1);
        probe("beq_fetch", 32'h100, 1'b1, 32'h100);
        @(posedge clk);
        #1;
        check("pulse_redirect_valid", 32'(redirect_valid), 32'h0);
        check("pulse_redirect_pc", redirect_pc, 32'h0);

        // Counter decay 2 -> 1 -> 0
        resolve(4'(BEQ), 32'h100, 16'hFFFF, '0, '0, 3'b000, 1'b1, 32'h100);
        check("nt1_redirect_valid", 32'(redirect_valid), 32'h1);
        check("nt1_redirect_pc", redirect_pc, 32'h104);
        probe("nt1_fetch", 32'h100, 1'b0, 32'h104);
        resolve(4'(BEQ), 32'h100, 16'hFFFF, '0, '0, 3'b000, 1'b0, 32'h104);
        check("nt2_redirect_valid", 32'(redirect_valid), 32'h0);
        probe("nt2_fetch", 32'h100, 1'b0, 32'h104);
        check("nt_branch_count", 32'(branch_count), 32'd3);
        check("nt_mispredict_count", 32'(mispredict_count), 32'd2);

        // J: correct prediction, then wrong target
        resolve(4'(J), 32'h4000_0010, '0, 26'h0AABBCC, '0, 3'b000, 1'b1, 32'h42AA_EF30);
        check("j_ok_redirect_valid", 32'(redirect_valid), 32'h0);
        resolve(4'(J), 32'h4000_0010, '0, 26'h0AABBCC, '0, 3'b000, 1'b1, 32'h42AA_EF34);
        check("j_bad_redirect_valid", 32'(redirect_valid), 32'h1);
        check("j_bad_redirect_pc", redirect_pc, 32'h42AA_EF30);
        probe("j_fetch", 32'h4000_0010, 1'b1, 32'h42AA_EF30);
        check("j_mispredict_count", 32'(mispredict_count), 32'd3);

        // JR redirect, then NONE ignored
        resolve(4'(JR), 32'h200, '0, '0, 32'hAABB_CCDD, 3'b000, 1'b0, '0);
        check("jr_redirect_valid", 32'(redirect_valid), 32'h1);
        check("jr_redirect_pc", redirect_pc, 32'hAABB_CCDD);
        resolve(4'(NONE), 32'h300, '0, '0, '0, 3'b111, 1'b1, 32'h999);
        check("none_redirect_valid", 32'(redirect_valid), 32'h0);
        check("none_branch_count", 32'(branch_count), 32'd6);
        check("none_mispredict_count", 32'(mispredict_count), 32'd4);

        // PC wrap on BGTZ and a correctly predicted not-taken BLTZ
        resolve(4'(BGTZ), 32'hFFFF_FFFC, 16'h0000, '0, '0, 3'b001, 1'b0, '0);
        check("wrap_redirect_valid", 32'(redirect_valid), 32'h1);
        check("wrap_redirect_pc", redirect_pc, 32'h0);
        resolve(4'(BLTZ), 32'h80, 16'h0010, '0, '0, 3'b001, 1'b0, 32'h84);
        check("bltz_nt_redirect_valid", 32'(redirect_valid), 32'h0);
        resolve(4'(BLEZ), 32'h80, 16'h0010, '0, '0, 3'b100, 1'b0, '0);
        check("blez_redirect_pc", redirect_pc, 32'hC4);

        // Aliasing at index 0
        resolve(4'(BEQ), 32'h500, 16'h0000, '0, '0, 3'b100, 1'b0, '0);
        check("alias_redirect_pc", redirect_pc, 32'h504);
        probe("alias_fetch100", 32'h100, 1'b0, 32'h104);
        probe("alias_fetch500", 32'h500, 1'b1, 32'h504);

        // Saturate stats with back-to-back mispredicts
        @(negedge clk);
        set_res(4'(JR), 32'h600, '0, '0, 32'h700, 3'b000, 1'b0, '0);
        repeat (65540) @(posedge clk);
        #1;
        check("sat_redirect_valid", 32'(redirect_valid), 32'h1);
        res_valid = 1'b0;
        check("sat_mispredict_count", 32'(mispredict_count), 32'hFFFF);
        check("sat_branch_count", 32'(branch_count), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
